// File: rtl/adder_result_accumulator.sv
// Accumulates BURST_LEN adder results {Carry_out, Sum} into a registered total and
// presents each burst total on a valid/ready port, with a sticky overflow flag.
module adder_result_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic [WIDTH-1:0]                 Sum,
    input  logic                             Carry_out,
    input  logic                             In_valid,
    output logic                             In_ready,
    input  logic                             Clear,
    output logic [ACC_WIDTH-1:0]             Acc_out,
    output logic                             Acc_valid,
    input  logic                             Acc_ready,
    output logic                             Overflow,
    output logic [$clog2(BURST_LEN+1)-1:0]   Count
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]       count, count_nxt;
    logic                   ovf, ovf_nxt;
    logic [ACC_WIDTH:0]     sum_wide;

    // One bit wider than the accumulator so the wrap shows up as the top bit.
    function automatic logic [ACC_WIDTH:0] add_wide(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [WIDTH:0]       r);
        return {1'b0, a} + (ACC_WIDTH+1)'(r);
    endfunction

    assign sum_wide = add_wide(acc, {Carry_out, Sum});

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        ovf_nxt   = ovf;
        if (Clear) begin
            // Abort wins over both a simultaneous accept and a simultaneous transfer.
            state_nxt = ACCUM;
            acc_nxt   = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (In_valid) begin
                        acc_nxt   = sum_wide[ACC_WIDTH-1:0];
                        count_nxt = count + CNT_W'(1);
                        if (sum_wide[ACC_WIDTH]) ovf_nxt = 1'b1;
                        if (count == LAST_CNT) state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (Acc_ready) begin
                        state_nxt = ACCUM;
                        acc_nxt   = '0;
                        count_nxt = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    assign In_ready  = (state == ACCUM);
    assign Acc_valid = (state == HOLD);
    assign Acc_out   = acc;
    assign Overflow  = ovf;
    assign Count     = count;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Drives three accumulator configurations with shared stimulus and checks each one
// against a burst-level reference model through per-instance scoreboards.
module tb_adder_result_accumulator;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] Sum = '0;
    logic       Carry_out = 1'b0;
    logic       In_valid = 1'b0;
    logic       Clear = 1'b0;
    logic       Acc_ready = 1'b0;

    logic [7:0] acc_out0, acc_out2;
    logic [5:0] acc_out1;
    logic [2:0] count0, count1;
    logic [0:0] count2;
    logic [2:0] in_ready, acc_valid, overflow;

    always #5 Clk = ~Clk;

    adder_result_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .BURST_LEN(4)) dut0 (
        .Clk(Clk), .Rst(Rst), .Sum(Sum), .Carry_out(Carry_out), .In_valid(In_valid),
        .In_ready(in_ready[0]), .Clear(Clear), .Acc_out(acc_out0), .Acc_valid(acc_valid[0]),
        .Acc_ready(Acc_ready), .Overflow(overflow[0]), .Count(count0));

    adder_result_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .BURST_LEN(4)) dut1 (
        .Clk(Clk), .Rst(Rst), .Sum(Sum), .Carry_out(Carry_out), .In_valid(In_valid),
        .In_ready(in_ready[1]), .Clear(Clear), .Acc_out(acc_out1), .Acc_valid(acc_valid[1]),
        .Acc_ready(Acc_ready), .Overflow(overflow[1]), .Count(count1));

    adder_result_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .BURST_LEN(1)) dut2 (
        .Clk(Clk), .Rst(Rst), .Sum(Sum), .Carry_out(Carry_out), .In_valid(In_valid),
        .In_ready(in_ready[2]), .Clear(Clear), .Acc_out(acc_out2), .Acc_valid(acc_valid[2]),
        .Acc_ready(Acc_ready), .Overflow(overflow[2]), .Count(count2));

    int ao [3];
    int cn [3];
    always_comb begin
        ao[0] = int'(acc_out0);
        ao[1] = int'(acc_out1);
        ao[2] = int'(acc_out2);
        cn[0] = int'(count0);
        cn[1] = int'(count1);
        cn[2] = int'(count2);
    end

    // Reference model: per instance, burst length, modulus, running true total.
    int bl  [3] = '{4, 4, 1};
    int lim [3] = '{256, 64, 256};
    int total_m [3];
    int cnt_m [3];
    bit hold_m [3];
    int exp_q [3][$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk or posedge Rst) begin
        for (int i = 0; i < 3; i++) begin
            if (Rst || Clear) begin
                hold_m[i]  = 1'b0;
                cnt_m[i]   = 0;
                total_m[i] = 0;
                exp_q[i].delete();
            end else if (hold_m[i]) begin
                if (Acc_ready) begin
                    hold_m[i]  = 1'b0;
                    cnt_m[i]   = 0;
                    total_m[i] = 0;
                end
            end else if (In_valid) begin
                total_m[i] += int'({Carry_out, Sum});
                cnt_m[i]++;
                if (cnt_m[i] == bl[i]) begin
                    exp_q[i].push_back(total_m[i] % lim[i]);
                    hold_m[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every instance each cycle, pops on a completed transfer.
    always @(negedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(!hold_m[i]));
            check($sformatf("acc_valid[%0d]", i), int'(acc_valid[i]), int'(hold_m[i]));
            check($sformatf("count[%0d]", i), cn[i], cnt_m[i]);
            check($sformatf("overflow[%0d]", i), int'(overflow[i]), int'(total_m[i] >= lim[i]));
            if (acc_valid[i]) begin
                check($sformatf("sb_depth[%0d]", i), exp_q[i].size(), 1);
                if (exp_q[i].size() > 0) begin
                    check($sformatf("acc_out[%0d]", i), ao[i], exp_q[i][0]);
                    if (Acc_ready && !Clear && !Rst) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [4:0] v, input bit iv, input bit clr, input bit ar);
        Sum       = v[3:0];
        Carry_out = v[4];
        In_valid  = iv;
        Clear     = clr;
        Acc_ready = ar;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bit prev;
        logic [4:0] seq_basic [4] = '{5'd21, 5'd24, 5'd16, 5'd8};

        #2 Rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), int'(in_ready[i]), 1);
            check($sformatf("rst_acc_valid[%0d]", i), int'(acc_valid[i]), 0);
            check($sformatf("rst_count[%0d]", i), cn[i], 0);
            check($sformatf("rst_overflow[%0d]", i), int'(overflow[i]), 0);
            check($sformatf("rst_acc_out[%0d]", i), ao[i], 0);
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Back-to-back burst.
        for (int k = 0; k < 4; k++) drive(seq_basic[k], 1'b1, 1'b0, 1'b1);
        check("basic_valid", int'(acc_valid[0]), 1);
        check("basic_out", ao[0], 69);
        check("basic_ovf", int'(overflow[0]), 0);
        check("basic_count", cn[0], 4);
        drive(5'd0, 1'b0, 1'b0, 1'b1);
        check("basic_ready_again", int'(in_ready[0]), 1);

        // Gaps between results and consumer backpressure.
        for (int k = 0; k < 4; k++) begin
            drive(seq_basic[k], 1'b1, 1'b0, 1'b0);
            if (k < 3) begin
                drive(5'd0, 1'b0, 1'b0, 1'b0);
                drive(5'd0, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            check("bp_out", ao[0], 69);
            check("bp_in_ready", int'(in_ready[0]), 0);
            drive(5'd0, 1'b0, 1'b0, k == 3);
        end
        check("bp_released", int'(in_ready[0]), 1);

        // Wrap in the 6-bit instance, then a clean burst.
        for (int k = 0; k < 4; k++) drive(5'd31, 1'b1, 1'b0, 1'b1);
        check("wrap_out", ao[1], 60);
        check("wrap_ovf", int'(overflow[1]), 1);
        drive(5'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) drive(5'd1, 1'b1, 1'b0, 1'b1);
        check("nowrap_out", ao[1], 4);
        check("nowrap_ovf", int'(overflow[1]), 0);
        drive(5'd0, 1'b0, 1'b0, 1'b1);

        // Clear collides with an accept.
        drive(5'd10, 1'b1, 1'b0, 1'b1);
        drive(5'd11, 1'b1, 1'b0, 1'b1);
        drive(5'd5, 1'b1, 1'b1, 1'b1);
        check("clear_count", cn[0], 0);
        for (int k = 1; k <= 4; k++) drive(5'(k), 1'b1, 1'b0, 1'b1);
        check("clear_out", ao[0], 10);
        check("clear_ovf", int'(overflow[0]), 0);
        drive(5'd0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 3; k++) drive(5'd15, 1'b1, 1'b0, 1'b1);
        In_valid = 1'b0;
        #2 Rst = 1'b1;
        #1;
        check("arst_valid", int'(acc_valid[0]), 0);
        check("arst_count", cn[0], 0);
        check("arst_out", ao[0], 0);
        check("arst_ready", int'(in_ready[0]), 1);
        @(posedge Clk); #1;
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(5'd15, 1'b1, 1'b0, 1'b1);
        check("arst_burst_out", ao[0], 60);
        drive(5'd0, 1'b0, 1'b0, 1'b1);

        // Single-result bursts alternate accept and hold.
        drive(5'd19, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            prev = acc_valid[2];
            drive(5'd19, 1'b1, 1'b0, 1'b1);
            check("bl1_alternate", int'(acc_valid[2]), int'(!prev));
            if (acc_valid[2]) check("bl1_out", ao[2], 19);
        end

        // Randomized traffic with occasional clears and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 599) begin
                #2 Rst = 1'b1;
                #1 Rst = 1'b0;
                @(posedge Clk); #1;
            end
            drive(5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
        end
        drive(5'd0, 1'b0, 1'b0, 1'b1);
        drive(5'd0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
